// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared BPSK sample format, FSM states and saturating negate
package bpsk_pkg;

    localparam int SAMPLE_W = 32;
    localparam int FRAC_W   = 20;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // The most negative 12.20 value has no positive twin; clamp to the largest positive.
    function automatic logic [SAMPLE_W-1:0] sat_neg(input logic [SAMPLE_W-1:0] x);
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return (~x) + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bpsk_sym_mult.sv
// rtl/bpsk_sym_mult.sv - registered +/-1 carrier multiply with one-cycle valid
module bpsk_sym_mult
    import bpsk_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] carrier,
    input  logic                symbol,
    input  logic                nco_flag,
    output logic [SAMPLE_W-1:0] dout,
    output logic                flag_out
);

    // dout keeps its last value between strobes so the DAC path sees a stable word.
    always_ff @(negedge clk) begin
        if (reset) begin
            dout     <= '0;
            flag_out <= 1'b0;
        end else begin
            flag_out <= nco_flag;
            if (nco_flag) begin
                dout <= symbol ? carrier : sat_neg(carrier);
            end
        end
    end

endmodule

// File: rtl/bpsk_mod.sv
// rtl/bpsk_mod.sv - byte-in BPSK modulator: holding buffer, bit serializer, symbol mapper
module bpsk_mod
    import bpsk_pkg::*;
#(
    parameter int SPS  = 16,
    parameter int DIFF = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          din,
    input  logic                flag_in,
    output logic                ready,
    input  logic [SAMPLE_W-1:0] carrier,
    input  logic                nco_flag,
    output logic [SAMPLE_W-1:0] dout,
    output logic                flag_out,
    output logic                busy
);

    localparam logic [15:0] SPS_LAST = 16'(SPS - 1);

    state_t      state, state_nxt;
    logic [7:0]  hold_reg;
    logic        hold_full;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [15:0] samp_cnt;
    logic        phase;

    logic        accept, load, strobe, bit_end, byte_end;
    logic        toggle, sym;

    assign ready  = !hold_full;
    assign accept = flag_in && !hold_full;
    assign busy   = (state == SEND);

    always_ff @(negedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // load covers both the IDLE->SEND transfer and the gapless reload at a byte end.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        strobe    = (state == SEND) && nco_flag;
        bit_end   = strobe && (samp_cnt == SPS_LAST);
        byte_end  = bit_end && (bit_cnt == 3'd7);
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (byte_end) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign toggle = (DIFF != 0) && shift[7] && (samp_cnt == 16'd0);
    assign sym    = (DIFF != 0) ? (phase ^ toggle) : shift[7];

    always_ff @(negedge clk) begin
        if (reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            samp_cnt  <= '0;
            phase     <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg  <= din;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                shift    <= hold_reg;
                bit_cnt  <= '0;
                samp_cnt <= '0;
            end else if (strobe) begin
                if (bit_end) begin
                    samp_cnt <= '0;
                    shift    <= {shift[6:0], 1'b0};
                    bit_cnt  <= bit_cnt + 3'd1;
                end else begin
                    samp_cnt <= samp_cnt + 16'd1;
                end
            end

            if (strobe && toggle) begin
                phase <= ~phase;
            end
        end
    end

    bpsk_sym_mult u_mult (
        .clk      (clk),
        .reset    (reset),
        .carrier  (carrier),
        .symbol   (sym),
        .nco_flag (strobe),
        .dout     (dout),
        .flag_out (flag_out)
    );

endmodule

// File: doc/bpsk_mod.md
# bpsk_mod

Transmit-side BPSK modulator, the counterpart of the receive mixer. It accepts data bytes under a flag/ready handshake and serializes them MSB-first, holding each bit for `SPS` carrier samples. Each carrier sample from the NCO is multiplied by ±1 and emitted as a 12.20 signed sample with a one-cycle valid flag. It sits between the framing logic and the DAC path, driven by the same NCO strobe that clocks the receive mixer.

## Interface
- `SPS`, 16: carrier samples per bit, 1..65535.
- `DIFF`, 0: 1 selects differential encoding (a data 1 toggles the phase, a data 0 holds it); 0 selects absolute encoding (1 → +carrier, 0 → −carrier).
- `clk` input, 1 bit: single clock; all state updates on the falling edge.
- `reset` input, 1 bit: synchronous, active-high.
- `din` input, 8 bits: data byte.
- `flag_in` input, 1 bit: `din` valid; accepted when `flag_in && ready`.
- `ready` output, 1 bit: holding register empty.
- `carrier` input, 32 bits: signed NCO sample, 12.20.
- `nco_flag` input, 1 bit: `carrier` valid strobe.
- `dout` output, 32 bits: signed modulated sample, 12.20.
- `flag_out` output, 1 bit: `dout` valid, one cycle.
- `busy` output, 1 bit: high while in SEND.

## Operation
- **Storage:** 8-bit holding register with a `hold_full` flag, plus an 8-bit shift register, a 3-bit bit counter, a 16-bit sample counter and a 1-bit phase register.
- **FSM, two states:**
  - IDLE → SEND on the first clock where `hold_full` is set: move the holding register into the shift register, clear `hold_full`, zero both counters.
  - In SEND, on each `nco_flag`:
    - Emit a sample.
    - Increment the sample counter. At `SPS-1` it wraps to 0, the shift register shifts left and the bit counter increments.
    - When the bit counter wraps from 7 and `hold_full` is set, reload the shift register in the same cycle. This gives back-to-back bytes with no gap sample.
    - When the bit counter wraps from 7 and `hold_full` is clear, return to IDLE.
  - Without `nco_flag`, nothing advances.
- **Symbol:** the current bit is `shift[7]`.
  - DIFF=0: symbol = bit.
  - DIFF=1: the phase register toggles when the bit is 1, at the first sample of that bit only, and symbol = phase after the update.
  - The phase register persists across IDLE and is cleared only by reset.
- **Arithmetic:**
  - symbol 1 → `dout = carrier`.
  - symbol 0 → `dout = -carrier`, two's complement. `-(32'h8000_0000)` saturates to `32'h7FFF_FFFF`.
  - No other width change; the output stays 12.20.
- **Handshake:** `ready = !hold_full`. An accept sets `hold_full` next edge. A simultaneous accept and reload (same cycle) is impossible because `ready` is low while full. An accept on the same cycle as the IDLE→SEND transfer is likewise blocked. `flag_in` while `ready` is low is ignored (no overwrite).
- **In IDLE:** `nco_flag` produces no `flag_out`, and `dout` holds its last value.
- **Reset (any state, including mid-byte):**
  - FSM → IDLE; holding and shift data discarded; counters and phase → 0.
  - Outputs: `dout = 0`, `flag_out = 0`, `busy = 0`, `ready = 1` on the edge following reset.

## Timing
- `nco_flag` at edge n produces `dout`/`flag_out` at edge n+1. `flag_out` is a one-cycle pulse, one per strobe while in SEND.
- The first output sample of a byte comes from the first `nco_flag` at or after the edge that enters SEND. Byte latency is 2 edges (accept, transfer) plus the wait for the strobe.
- A byte spans exactly 8·`SPS` strobes. Bit boundaries are at multiples of `SPS` counted from the byte's first strobe.
- `nco_flag` asserted on every cycle is legal; full throughput is one sample per cycle.
- `busy` falls on the edge that processes the last strobe of the last byte; that strobe's `flag_out` appears on the same edge.

## Structure
- A shared package `bpsk_pkg` holds:
  - the sample width (32) and fraction bits (20) constants;
  - the state enum `{IDLE, SEND}`;
  - the saturating-negate function, also usable by the receive path.
- One natural sub-module is `bpsk_sym_mult`: registered ±1 multiply with saturation, taking `carrier`, `symbol` and `nco_flag` and producing `dout` and `flag_out`. The top holds the FSM, buffers and counters.

## Test plan
- **Reset:** `reset` high for 3 clocks with `nco_flag` toggling → `dout=0`, `flag_out=0`, `ready=1`, `busy=0` throughout and one edge after release.
- **Single byte, absolute:** SPS=2, DIFF=0, `din=8'hA5`, `carrier` constant `32'h0010_0000` (+1.0), `nco_flag` every cycle → 16 samples with signs + + − − + + − − − − + + − − + + (per bit: 1,0,1,0,0,1,0,1), then `busy=0` and no further `flag_out`.
- **Back-to-back:** SPS=1, bytes `8'hFF` then `8'h00` offered while `ready` → 16 contiguous `flag_out` pulses, 8 positive then 8 negative, no gap; `ready` low only while the holding register is full.
- **Differential:** SPS=1, DIFF=1, `din=8'b1100_0001`, carrier +1.0 → phases 1,0,0,0,0,0,0,1, giving `dout` +,−,−,−,−,−,−,+. A second byte `8'h00` holds the phase, giving all +.
- **Saturation and sparse strobe:**
  - `carrier=32'h8000_0000` with bit 0 → `dout=32'h7FFF_FFFF`.
  - `nco_flag` every 3rd cycle → sample and bit counts advance only on strobes.
- **Reset mid-byte:** assert `reset` after 5 of 16 samples of `8'hA5` (SPS=2) → no further `flag_out`. A new byte `8'h80` then transmits from bit 7 with the phase cleared.
